// File: rtl/rgb_pwm_gen.sv
// Three-channel RGB PWM generator with boundary-synchronised settings update.
// New duty/top values are staged on load and only become active on a period
// boundary, so a period always completes with the values it started with.
// Optional build macro: RGB_PWM_ACTIVE_LOW_EN inverts Red/Green/Blue for
// common-anode LEDs (reset level and duty=0 level become 1).
module rgb_pwm_gen #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] duty_r,
  input  logic [CNT_W-1:0] duty_g,
  input  logic [CNT_W-1:0] duty_b,
  input  logic [CNT_W-1:0] top,
  output logic             pending,
  output logic             period_start,
  output logic             Red,
  output logic             Green,
  output logic             Blue
);

  localparam int unsigned     PreW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);

`ifdef RGB_PWM_ACTIVE_LOW_EN
  localparam logic OutInv = 1'b1;
`else
  localparam logic OutInv = 1'b0;
`endif

  logic [PreW-1:0]  pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [CNT_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d, top_q, top_d;
  logic [CNT_W-1:0] stg_r_q, stg_r_d, stg_g_q, stg_g_d, stg_b_q, stg_b_d;
  logic [CNT_W-1:0] stg_top_q, stg_top_d;
  logic             pending_q, pending_d;
  logic             period_start_q, period_start_d;
  logic             red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic             tick, boundary;

  assign tick     = (pre_cnt_q == PreLast);
  assign boundary = tick && (pwm_cnt_q == top_q);

  // Prescaler and period counter; the counter wraps to 0 on a boundary.
  always_comb begin
    pre_cnt_d      = tick ? '0 : pre_cnt_q + PreW'(1);
    pwm_cnt_d      = pwm_cnt_q;
    if (tick) begin
      pwm_cnt_d = boundary ? '0 : pwm_cnt_q + CNT_W'(1);
    end
    period_start_d = boundary;
  end

  // Staging and commit of settings; a load coinciding with a boundary bypasses staging.
  always_comb begin
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    top_d     = top_q;
    stg_r_d   = stg_r_q;
    stg_g_d   = stg_g_q;
    stg_b_d   = stg_b_q;
    stg_top_d = stg_top_q;
    pending_d = pending_q;
    if (load && boundary) begin
      r_d       = duty_r;
      g_d       = duty_g;
      b_d       = duty_b;
      top_d     = top;
      pending_d = 1'b0;
    end else if (load) begin
      stg_r_d   = duty_r;
      stg_g_d   = duty_g;
      stg_b_d   = duty_b;
      stg_top_d = top;
      pending_d = 1'b1;
    end else if (boundary && pending_q) begin
      r_d       = stg_r_q;
      g_d       = stg_g_q;
      b_d       = stg_b_q;
      top_d     = stg_top_q;
      pending_d = 1'b0;
    end
  end

  // Duty compare against the current count; outputs are registered (one clk lag).
  always_comb begin
    red_d   = (pwm_cnt_q < r_q) ^ OutInv;
    green_d = (pwm_cnt_q < g_q) ^ OutInv;
    blue_d  = (pwm_cnt_q < b_q) ^ OutInv;
  end

  // State registers with asynchronous clear to the reset state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q      <= '0;
      pwm_cnt_q      <= '0;
      r_q            <= '0;
      g_q            <= '0;
      b_q            <= '0;
      top_q          <= '1;
      stg_r_q        <= '0;
      stg_g_q        <= '0;
      stg_b_q        <= '0;
      stg_top_q      <= '0;
      pending_q      <= 1'b0;
      period_start_q <= 1'b0;
      red_q          <= OutInv;
      green_q        <= OutInv;
      blue_q         <= OutInv;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      r_q            <= r_d;
      g_q            <= g_d;
      b_q            <= b_d;
      top_q          <= top_d;
      stg_r_q        <= stg_r_d;
      stg_g_q        <= stg_g_d;
      stg_b_q        <= stg_b_d;
      stg_top_q      <= stg_top_d;
      pending_q      <= pending_d;
      period_start_q <= period_start_d;
      red_q          <= red_d;
      green_q        <= green_d;
      blue_q         <= blue_d;
    end
  end

  assign pending      = pending_q;
  assign period_start = period_start_q;
  assign Red          = red_q;
  assign Green        = green_q;
  assign Blue         = blue_q;

endmodule

// File: tb/tb_rgb_pwm_gen.sv
// Bench for rgb_pwm_gen: two instances (PRESCALE=1 and PRESCALE=4). Each
// period (period_start to period_start) is measured as a window of clk length
// and per-channel high counts, and compared against expected windows queued
// when the corresponding settings are driven.
module tb_rgb_pwm_gen;

  typedef struct packed {
    logic [31:0] len;
    logic [31:0] r;
    logic [31:0] g;
    logic [31:0] b;
  } win_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       load0 = 1'b0, load1 = 1'b0;
  logic [7:0] dr0 = '0, dg0 = '0, db0 = '0, top0 = '0;
  logic [7:0] dr1 = '0, dg1 = '0, db1 = '0, top1 = '0;
  logic       pend0, ps0, red0, grn0, blu0;
  logic       pend1, ps1, red1, grn1, blu1;

  win_t q0[$];
  win_t q1[$];
  logic [1:0] arm = 2'b01;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rgb_pwm_gen #(.CNT_W(8), .PRESCALE(1)) u_dut0 (
    .clk(clk), .rst(rst), .load(load0), .duty_r(dr0), .duty_g(dg0), .duty_b(db0), .top(top0),
    .pending(pend0), .period_start(ps0), .Red(red0), .Green(grn0), .Blue(blu0)
  );

  rgb_pwm_gen #(.CNT_W(8), .PRESCALE(4)) u_dut1 (
    .clk(clk), .rst(rst), .load(load1), .duty_r(dr1), .duty_g(dg1), .duty_b(db1), .top(top1),
    .pending(pend1), .period_start(ps1), .Red(red1), .Green(grn1), .Blue(blu1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic win_t mk_win(input int unsigned len, input int unsigned r,
                                  input int unsigned g, input int unsigned b);
    win_t w;
    w.len = len; w.r = r; w.g = g; w.b = b;
    return w;
  endfunction

  // Called at a negedge; drives a one-clk load and returns at the following negedge.
  task automatic load_dut(input int idx, input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b, input logic [7:0] t);
    if (idx == 0) begin
      dr0 = r; dg0 = g; db0 = b; top0 = t; load0 = 1'b1;
    end else begin
      dr1 = r; dg1 = g; db1 = b; top1 = t; load1 = 1'b1;
    end
    @(negedge clk);
    load0 = 1'b0;
    load1 = 1'b0;
  endtask

  // Wait for n period_start pulses on instance idx, bounded per pulse.
  task automatic wait_ps(input int idx, input int n);
    logic seen;
    for (int k = 0; k < n; k++) begin
      seen = 1'b0;
      for (int c = 0; c < 4000 && !seen; c++) begin
        @(negedge clk);
        seen = (idx == 0) ? ps0 : ps1;
      end
      if (!seen) begin
        check_eq($sformatf("ps_timeout%0d", idx), {31'd0, seen}, 32'd1);
        return;
      end
    end
  endtask

  // Period monitor: window covers the clks after a period_start up to and
  // including the next one, which matches the 1-clk compare lag.
  initial begin
    int unsigned m_len[2], m_r[2], m_g[2], m_b[2];
    logic [1:0] psw, rw, gw, bw;
    win_t e;
    int has;
    forever begin
      @(negedge clk);
      psw = {ps1, ps0};
      rw  = {red1, red0};
      gw  = {grn1, grn0};
      bw  = {blu1, blu0};
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          m_len[i] = 0; m_r[i] = 0; m_g[i] = 0; m_b[i] = 0;
        end else begin
          m_len[i]++;
          m_r[i] += int'(rw[i]);
          m_g[i] += int'(gw[i]);
          m_b[i] += int'(bw[i]);
          if (psw[i]) begin
            if (arm[i]) begin
              has = (i == 0) ? q0.size() : q1.size();
              check_eq($sformatf("exp_avail%0d", i), (has != 0) ? 32'd1 : 32'd0, 32'd1);
              if (has != 0) begin
                e = (i == 0) ? q0.pop_front() : q1.pop_front();
                check_eq($sformatf("len%0d", i),   m_len[i], e.len);
                check_eq($sformatf("red%0d", i),   m_r[i],   e.r);
                check_eq($sformatf("green%0d", i), m_g[i],   e.g);
                check_eq($sformatf("blue%0d", i),  m_b[i],   e.b);
              end
            end
            m_len[i] = 0; m_r[i] = 0; m_g[i] = 0; m_b[i] = 0;
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_pending", {31'd0, pend0}, 32'd0);
    check_eq("rst_ps",      {31'd0, ps0},   32'd0);
    check_eq("rst_red",     {31'd0, red0},  32'd0);
    check_eq("rst_green",   {31'd0, grn0},  32'd0);
    check_eq("rst_blue",    {31'd0, blu0},  32'd0);
    check_eq("rst_red4",    {31'd0, red1},  32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    q0.push_back(mk_win(256, 0, 0, 0));

    // Staged load during the reset-default period
    repeat (3) @(negedge clk);
    load_dut(0, 8'd3, 8'd0, 8'd10, 8'd9);
    check_eq("pend_after_load", {31'd0, pend0}, 32'd1);
    for (int i = 0; i < 3; i++) q0.push_back(mk_win(10, 3, 0, 10));
    wait_ps(0, 1);
    check_eq("pend_commit", {31'd0, pend0}, 32'd0);
    wait_ps(0, 3);

    // Two loads in one period: last one wins at the boundary
    q0.push_back(mk_win(10, 3, 0, 10));
    q0.push_back(mk_win(10, 7, 0, 10));
    repeat (2) @(negedge clk);
    load_dut(0, 8'd5, 8'd0, 8'd10, 8'd9);
    check_eq("pend_load5", {31'd0, pend0}, 32'd1);
    repeat (1) @(negedge clk);
    load_dut(0, 8'd7, 8'd0, 8'd10, 8'd9);
    check_eq("pend_load7", {31'd0, pend0}, 32'd1);
    wait_ps(0, 1);
    check_eq("pend_clear7", {31'd0, pend0}, 32'd0);

    // Load on the boundary clk: applied directly, pending never asserts
    for (int i = 0; i < 3; i++) q0.push_back(mk_win(4, 1, 0, 4));
    repeat (9) @(negedge clk);
    load_dut(0, 8'd1, 8'd0, 8'd10, 8'd3);
    check_eq("coinc_ps",   {31'd0, ps0},   32'd1);
    check_eq("coinc_pend", {31'd0, pend0}, 32'd0);
    @(negedge clk);
    check_eq("coinc_pend2", {31'd0, pend0}, 32'd0);
    wait_ps(0, 3);

    // Mid-period asynchronous reset with Red high and a load pending
    q0.push_back(mk_win(4, 1, 0, 4));
    @(negedge clk);
    load_dut(0, 8'd8, 8'd0, 8'd10, 8'd9);
    wait_ps(0, 1);
    repeat (3) @(negedge clk);
    load_dut(0, 8'd8, 8'd0, 8'd10, 8'd9);
    check_eq("pre_rst_pend", {31'd0, pend0}, 32'd1);
    check_eq("pre_rst_red",  {31'd0, red0},  32'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("arst_red",     {31'd0, red0},  32'd0);
    check_eq("arst_blue",    {31'd0, blu0},  32'd0);
    check_eq("arst_pend",    {31'd0, pend0}, 32'd0);
    check_eq("arst_cnt",     {24'd0, u_dut0.pwm_cnt_q}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // After reset: default 256-tick period; PRESCALE=4 instance also exercised
    q0.push_back(mk_win(256, 0, 0, 0));
    q1.push_back(mk_win(1024, 0, 0, 0));
    for (int i = 0; i < 3; i++) q1.push_back(mk_win(20, 8, 0, 20));
    arm = 2'b11;
    @(negedge clk);
    load_dut(1, 8'd2, 8'd0, 8'd5, 8'd4);
    check_eq("pend4_load", {31'd0, pend1}, 32'd1);
    wait_ps(0, 1);
    arm[0] = 1'b0;
    wait_ps(1, 1);
    check_eq("pend4_commit", {31'd0, pend1}, 32'd0);
    wait_ps(1, 3);
    @(negedge clk);

    check_eq("q0_left", q0.size(), 32'd0);
    check_eq("q1_left", q1.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
